// File: rtl/basic_unpacker_pkg.sv
// Shared constants and types for basic_unpacker.
// The BASIC_UNPACKER_PARITY_EN macro adds a parity helper used for out_parity.
package basic_unpacker_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned WIDE_WIDTH_DEF = (256 * 4) / 8;

  typedef enum logic {IDLE, SEND} unpack_state_t;

`ifdef BASIC_UNPACKER_PARITY_EN
  // Wide enough for any practical beat width; callers zero-extend.
  localparam int unsigned ParityMaxW = 1024;

  function automatic logic even_parity(input logic [ParityMaxW-1:0] v);
    return ^v;
  endfunction
`endif

endpackage

// File: rtl/basic_unpacker.sv
// Width-down converter: one wide word in, NUM_BEATS narrow beats out, LSB beat first.
// Define BASIC_UNPACKER_PARITY_EN to add the registered out_parity output.
module basic_unpacker
  import basic_unpacker_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned WIDE_WIDTH = WIDE_WIDTH_DEF,
  localparam int unsigned NUM_BEATS = WIDE_WIDTH / DATA_WIDTH,
  localparam int unsigned CNT_W     = $clog2(NUM_BEATS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDE_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [CNT_W-1:0]      out_beat_idx
`ifdef BASIC_UNPACKER_PARITY_EN
  ,
  output logic                  out_parity
`endif
);

  unpack_state_t         state_q, state_d;
  logic [WIDE_WIDTH-1:0] shift_q, shift_d;
  logic [WIDE_WIDTH-1:0] shift_nxt;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [CNT_W-1:0]      idx_q, idx_d;
  logic                  load_word;

  assign shift_nxt = shift_q >> DATA_WIDTH;

  // Accept in IDLE, or on the last-beat handshake so words stream without a bubble.
  assign in_ready = !rst && ((state_q == IDLE) || (last_q && out_ready));

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    idx_d     = idx_q;
    load_word = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) load_word = 1'b1;
      end
      SEND: begin
        if (out_ready) begin
          if (!last_q) begin
            shift_d = shift_nxt;
            data_d  = shift_nxt[DATA_WIDTH-1:0];
            idx_d   = idx_q + CNT_W'(1);
            last_d  = ((idx_q + CNT_W'(1)) == CNT_W'(NUM_BEATS - 1));
          end else if (in_valid) begin
            load_word = 1'b1;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_word) begin
      state_d = SEND;
      shift_d = in_data;
      data_d  = in_data[DATA_WIDTH-1:0];
      valid_d = 1'b1;
      last_d  = 1'b0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
    end
  end

  assign out_data     = data_q;
  assign out_valid    = valid_q;
  assign out_last     = last_q;
  assign out_beat_idx = idx_q;

`ifdef BASIC_UNPACKER_PARITY_EN
  logic parity_q, parity_d;

  // Derived from the next data value so parity tracks out_data through stalls.
  assign parity_d = even_parity(ParityMaxW'(data_d));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= parity_d;
  end

  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_basic_unpacker.sv
// Self-checking bench for basic_unpacker using a beat scoreboard.
// Define BASIC_UNPACKER_PARITY_EN to also exercise out_parity.
module tb_basic_unpacker;

  localparam int unsigned DW = 8;
  localparam int unsigned WW = 128;
  localparam int unsigned NB = WW / DW;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [CW-1:0] idx;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [WW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [CW-1:0] out_beat_idx;
`ifdef BASIC_UNPACKER_PARITY_EN
  logic          out_parity;
`endif

  int checks = 0;
  int errors = 0;
  beat_t sb[$];

  basic_unpacker dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .out_beat_idx (out_beat_idx)
`ifdef BASIC_UNPACKER_PARITY_EN
    ,
    .out_parity   (out_parity)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [WW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task push_word(input logic [WW-1:0] w);
    beat_t b;
    for (int i = 0; i < NB; i++) begin
      b.data = w[i*DW +: DW];
      b.last = (i == NB - 1);
      b.idx  = CW'(i);
      sb.push_back(b);
    end
  endtask

  // Pops one expected beat per observed handshake.
  task run_monitor();
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected got data=%h last=%b idx=%0d want no beat",
                   out_data, out_last, out_beat_idx);
        end else begin
          e = sb.pop_front();
          if ({out_data, out_last, out_beat_idx} !== {e.data, e.last, e.idx}) begin
            errors++;
            $display("FAIL beat got data=%h last=%b idx=%0d want data=%h last=%b idx=%0d",
                     out_data, out_last, out_beat_idx, e.data, e.last, e.idx);
          end
`ifdef BASIC_UNPACKER_PARITY_EN
          checks++;
          if (out_parity !== ^e.data) begin
            errors++;
            $display("FAIL beat_parity got %b want %b", out_parity, ^e.data);
          end
`endif
        end
      end
    end
  endtask

  task send_word(input logic [WW-1:0] w);
    int n;
    n        = 0;
    in_data  = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%b want 1", in_ready);
    end else begin
      push_word(w);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = rand_word();
  endtask

  task wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d want 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task wait_beat(input logic [CW-1:0] idx);
    int n;
    n = 0;
    while (!(out_valid && out_beat_idx == idx) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (!(out_valid && out_beat_idx == idx)) begin
      errors++;
      $display("FAIL wait_beat got idx=%0d valid=%b want idx=%0d", out_beat_idx, out_valid, idx);
    end
  endtask

  task test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = rand_word();
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 0", in_ready);
    end
    checks++;
    if ({out_valid, out_data} !== {1'b0, {DW{1'b0}}}) begin
      errors++;
      $display("FAIL reset_out got valid=%b data=%h want 0 00", out_valid, out_data);
    end
    checks++;
    if ({out_last, out_beat_idx} !== {1'b0, {CW{1'b0}}}) begin
      errors++;
      $display("FAIL reset_last_idx got last=%b idx=%0d want 0 0", out_last, out_beat_idx);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_in_ready got %b want 1", in_ready);
    end
  endtask

  task test_single();
    out_ready = 1'b1;
    send_word(128'h0F0E0D0C0B0A09080706050403020100);
    wait_drain();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL single_idle got valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task test_back_to_back();
    int   vcnt;
    int   rbad;
    logic rlast;
    vcnt      = 0;
    rbad      = 0;
    rlast     = 1'b0;
    out_ready = 1'b1;
    fork
      begin
        send_word({WW{1'b0}});
        send_word({WW{1'b1}});
      end
      begin
        for (int k = 1; k <= 34; k++) begin
          @(negedge clk);
          if (k >= 2 && k <= 33 && out_valid) vcnt++;
          if (k >= 2 && k <= 16 && in_ready) rbad++;
          if (k == 17) rlast = in_ready;
        end
      end
    join
    checks++;
    if (vcnt != 2 * NB) begin
      errors++;
      $display("FAIL b2b_valid_beats got %0d want %0d", vcnt, 2 * NB);
    end
    checks++;
    if (rbad != 0) begin
      errors++;
      $display("FAIL b2b_early_in_ready got %0d want 0", rbad);
    end
    checks++;
    if (rlast !== 1'b1) begin
      errors++;
      $display("FAIL b2b_last_in_ready got %b want 1", rlast);
    end
    wait_drain();
  endtask

  task test_backpressure();
    out_ready = 1'b1;
    send_word(128'h0F0E0D0C0B0A09080706050403020100);
    wait_beat(CW'(5));
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_data, out_beat_idx, in_ready} !== {1'b1, 8'h05, 4'd5, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold got valid=%b data=%h idx=%0d in_ready=%b want 1 05 5 0",
                 out_valid, out_data, out_beat_idx, in_ready);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_drain();
  endtask

  task test_reset_mid_word();
    out_ready = 1'b1;
    send_word(rand_word());
    wait_beat(CW'(7));
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    checks++;
    if ({out_valid, out_data, out_last, out_beat_idx, in_ready} !==
        {1'b0, {DW{1'b0}}, 1'b0, {CW{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got valid=%b data=%h last=%b idx=%0d in_ready=%b want all 0",
               out_valid, out_data, out_last, out_beat_idx, in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_word({(WW / 8){8'hA5}});
    wait_drain();
  endtask

`ifdef BASIC_UNPACKER_PARITY_EN
  task test_parity();
    logic [2:0] par_exp;
    par_exp   = 3'b101;
    out_ready = 1'b1;
    send_word({104'h0, 8'h07, 8'h03, 8'h01});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_parity !== par_exp[k]) begin
        errors++;
        $display("FAIL parity_beat%0d got %b want %b", k, out_parity, par_exp[k]);
      end
    end
    wait_drain();
  endtask
`endif

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    fork
      run_monitor();
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
`ifdef BASIC_UNPACKER_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
